// File: rtl/gt_link_mgr.sv
// gt_link_mgr: GT TX user-clock domain link sequencer. Generates the TX datapath reset and,
// per channel, debounces block lock into link_up and retrains the RX datapath on lock timeout.
module gt_link_mgr #(
  parameter int CHANNELS             = 2,
  parameter int RST_SYNC_N           = 4,
  parameter int DEBOUNCE_CYCLES      = 1024,
  parameter int LOCK_TIMEOUT_CYCLES  = 65536,
  parameter int RETRAIN_PULSE_CYCLES = 16,
  parameter int CNT_W                = 17
) (
  input  logic                  gt_txusrclk,
  input  logic                  gt_tx_reset,
  input  logic                  gt_reset_tx_done,
  input  logic                  gt_reset_rx_done,
  input  logic [CHANNELS-1:0]   rx_block_lock,
  input  logic [CHANNELS-1:0]   rx_high_ber,
  output logic                  userclk_tx_active,
  output logic                  tx_rst,
  output logic [CHANNELS-1:0]   link_up,
  output logic                  rx_datapath_reset,
  output logic [8*CHANNELS-1:0] retrain_count,
  output logic [CHANNELS-1:0]   status_led
);

  // state       | meaning
  // S_RESET     | held until TX datapath out of reset and RX reset done
  // S_WAIT_LOCK | hunting for block lock, timeout counter running
  // S_DEBOUNCE  | counting consecutive clean-lock cycles
  // S_UP        | link up
  // S_RETRAIN   | requesting rx datapath reset
  // S_RXWAIT    | waiting for the GT RX reset to cycle low then high
  typedef enum logic [2:0] {
    S_RESET, S_WAIT_LOCK, S_DEBOUNCE, S_UP, S_RETRAIN, S_RXWAIT
  } state_t;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PL_LAST = CNT_W'(RETRAIN_PULSE_CYCLES - 1);

  logic                  tx_done_meta_q, rx_done_meta_q, tx_done_s, rx_done_s;
  logic [CHANNELS-1:0]   lock_meta_q, ber_meta_q, lock_s, ber_s;
  logic                  rx_done_prev_q, uca_q, rxdp_q;
  logic [RST_SYNC_N-1:0] rst_sr_q;
  logic [23:0]           blink_q;
  logic [CHANNELS-1:0]   link_up_q, led_q, seen0_q, seen0_d, req, good;
  logic                  rx_fall;

  state_t           state_q [CHANNELS];
  state_t           state_d [CHANNELS];
  logic [CNT_W-1:0] cnt_q   [CHANNELS];
  logic [CNT_W-1:0] cnt_d   [CHANNELS];
  logic [7:0]       rtc_q   [CHANNELS];
  logic [7:0]       rtc_d   [CHANNELS];

  assign good    = lock_s & ~ber_s;
  assign rx_fall = rx_done_prev_q & ~rx_done_s;
  assign tx_rst  = ~rst_sr_q[RST_SYNC_N-1];

  always_ff @(posedge gt_txusrclk or posedge gt_tx_reset) begin
    if (gt_tx_reset) begin
      tx_done_meta_q <= 1'b0;
      tx_done_s      <= 1'b0;
      rx_done_meta_q <= 1'b0;
      rx_done_s      <= 1'b0;
      lock_meta_q    <= '0;
      lock_s         <= '0;
      ber_meta_q     <= '0;
      ber_s          <= '0;
      rx_done_prev_q <= 1'b0;
      uca_q          <= 1'b0;
      rst_sr_q       <= '0;
      blink_q        <= '0;
      rxdp_q         <= 1'b0;
      link_up_q      <= '0;
      led_q          <= '0;
    end else begin
      tx_done_meta_q <= gt_reset_tx_done;
      tx_done_s      <= tx_done_meta_q;
      rx_done_meta_q <= gt_reset_rx_done;
      rx_done_s      <= rx_done_meta_q;
      lock_meta_q    <= rx_block_lock;
      lock_s         <= lock_meta_q;
      ber_meta_q     <= rx_high_ber;
      ber_s          <= ber_meta_q;
      rx_done_prev_q <= rx_done_s;
      uca_q          <= 1'b1;
      // Shift register fills with ones only while tx_done_s holds; any drop empties it.
      rst_sr_q       <= tx_done_s ? RST_SYNC_N'({rst_sr_q, 1'b1}) : '0;
      blink_q        <= blink_q + 24'd1;
      rxdp_q         <= |req;
      for (int c = 0; c < CHANNELS; c++) begin
        link_up_q[c] <= (state_q[c] == S_UP);
        led_q[c]     <= (state_q[c] == S_UP) ||
                        (((state_q[c] == S_WAIT_LOCK) || (state_q[c] == S_DEBOUNCE)) && blink_q[23]);
      end
    end
  end

  always_ff @(posedge gt_txusrclk or posedge gt_tx_reset) begin
    if (gt_tx_reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= S_RESET;
        cnt_q[c]   <= '0;
        rtc_q[c]   <= '0;
      end
      seen0_q <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
        rtc_q[c]   <= rtc_d[c];
      end
      seen0_q <= seen0_d;
    end
  end

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
      rtc_d[c]   = rtc_q[c];
      req[c]     = (state_q[c] == S_RETRAIN);
      seen0_d[c] = (state_q[c] == S_RXWAIT) && (seen0_q[c] || !rx_done_s);
      // A retrain pulse always runs to completion so the GT sees a full-width reset.
      if ((state_q[c] != S_RETRAIN) &&
          (tx_rst || (rx_fall && (state_q[c] != S_RXWAIT)))) begin
        state_d[c] = S_RESET;
        cnt_d[c]   = '0;
      end else begin
        case (state_q[c])
          S_RESET: begin
            if (rx_done_s) begin
              state_d[c] = S_WAIT_LOCK;
              cnt_d[c]   = '0;
            end
          end
          S_WAIT_LOCK: begin
            if (good[c]) begin
              state_d[c] = S_DEBOUNCE;
              cnt_d[c]   = '0;
            end else if (cnt_q[c] == TO_LAST) begin
              state_d[c] = S_RETRAIN;
              cnt_d[c]   = '0;
            end else begin
              cnt_d[c] = cnt_q[c] + CNT_W'(1);
            end
          end
          S_DEBOUNCE: begin
            if (!good[c]) begin
              state_d[c] = S_WAIT_LOCK;
              cnt_d[c]   = '0;
            end else if (cnt_q[c] == DB_LAST) begin
              state_d[c] = S_UP;
              cnt_d[c]   = '0;
            end else begin
              cnt_d[c] = cnt_q[c] + CNT_W'(1);
            end
          end
          S_UP: begin
            if (!good[c]) begin
              state_d[c] = S_WAIT_LOCK;
              cnt_d[c]   = '0;
            end
          end
          S_RETRAIN: begin
            if (cnt_q[c] == PL_LAST) begin
              state_d[c] = S_RXWAIT;
              cnt_d[c]   = '0;
            end else begin
              cnt_d[c] = cnt_q[c] + CNT_W'(1);
            end
          end
          S_RXWAIT: begin
            if (seen0_q[c] && rx_done_s) begin
              state_d[c] = S_WAIT_LOCK;
              cnt_d[c]   = '0;
            end
          end
          default: begin
            state_d[c] = S_RESET;
            cnt_d[c]   = '0;
          end
        endcase
      end
      if ((state_d[c] == S_RETRAIN) && (state_q[c] != S_RETRAIN) && (rtc_q[c] != 8'hFF))
        rtc_d[c] = rtc_q[c] + 8'd1;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_rtc
    assign retrain_count[8*c +: 8] = rtc_q[c];
  end

  assign userclk_tx_active = uca_q;
  assign link_up           = link_up_q;
  assign status_led        = led_q;
  assign rx_datapath_reset = rxdp_q;

endmodule

// File: tb/tb_gt_link_mgr.sv
// tb_gt_link_mgr: directed stimulus for gt_link_mgr with a cycle-level behavioural
// model compared every cycle, plus hand-computed timing pins.
module tb_gt_link_mgr;
  localparam int CH = 2;
  localparam int RST_SYNC_N = 4, DB = 8, TO = 32, PULSE = 4;
  localparam int P_IDLE = 0, P_HUNT = 1, P_UP = 2, P_PULSE = 3, P_RXW = 4;

  logic          gt_txusrclk = 1'b0;
  logic          gt_tx_reset = 1'b1;
  logic          gt_reset_tx_done, gt_reset_rx_done;
  logic [CH-1:0] rx_block_lock, rx_high_ber;
  logic          userclk_tx_active, tx_rst, rx_datapath_reset;
  logic [CH-1:0] link_up, status_led;
  logic [8*CH-1:0] retrain_count;

  int total = 0, bad = 0;
  bit chk_en = 0;

  gt_link_mgr #(
    .CHANNELS(CH), .RST_SYNC_N(RST_SYNC_N), .DEBOUNCE_CYCLES(DB),
    .LOCK_TIMEOUT_CYCLES(TO), .RETRAIN_PULSE_CYCLES(PULSE), .CNT_W(17)
  ) dut (
    .gt_txusrclk(gt_txusrclk), .gt_tx_reset(gt_tx_reset),
    .gt_reset_tx_done(gt_reset_tx_done), .gt_reset_rx_done(gt_reset_rx_done),
    .rx_block_lock(rx_block_lock), .rx_high_ber(rx_high_ber),
    .userclk_tx_active(userclk_tx_active), .tx_rst(tx_rst), .link_up(link_up),
    .rx_datapath_reset(rx_datapath_reset), .retrain_count(retrain_count),
    .status_led(status_led)
  );

  always #5 gt_txusrclk = ~gt_txusrclk;

  // Model: HUNT covers both lock search and debounce; a channel is up on its
  // (DB+1)th consecutive clean sample, and times out after TO unclean samples
  // counted from the last (re)start of the hunt.
  int ph[CH], clean[CH], bad_n[CH], left[CH], rtc[CH];
  bit seen[CH];
  bit m_uca, m_txrst, m_rxdp;
  bit [CH-1:0] m_link, m_led;
  int run;
  longint ticks;
  bit txd1, txd2, rxd1, rxd2, rx_prev;
  bit [CH-1:0] lk1, lk2, br1, br2;

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      ph[c] = P_IDLE; clean[c] = 0; bad_n[c] = 0; left[c] = 0; rtc[c] = 0; seen[c] = 0;
    end
    m_uca = 0; m_txrst = 1; m_rxdp = 0; m_link = '0; m_led = '0;
    run = 0; ticks = 0;
    txd1 = 0; txd2 = 0; rxd1 = 0; rxd2 = 0; rx_prev = 0;
    lk1 = '0; lk2 = '0; br1 = '0; br2 = '0;
  endtask

  task automatic start_hunt(input int c);
    ph[c] = P_HUNT; clean[c] = 0; bad_n[c] = 0;
  endtask

  task automatic model_step();
    bit any_p, fall, good;
    any_p = 0;
    for (int c = 0; c < CH; c++) begin
      if (ph[c] == P_PULSE) any_p = 1;
      m_link[c] = (ph[c] == P_UP);
      m_led[c]  = (ph[c] == P_UP) || (ph[c] == P_HUNT && ticks[23]);
    end
    fall = rx_prev && !rxd2;
    for (int c = 0; c < CH; c++) begin
      good = lk2[c] && !br2[c];
      if (ph[c] != P_PULSE && (m_txrst || (fall && ph[c] != P_RXW))) ph[c] = P_IDLE;
      else begin
        case (ph[c])
          P_IDLE: if (rxd2) start_hunt(c);
          P_HUNT: begin
            if (good) begin
              clean[c]++;
              if (clean[c] == DB + 1) ph[c] = P_UP;
            end else if (clean[c] > 0) begin
              clean[c] = 0; bad_n[c] = 0;
            end else begin
              bad_n[c]++;
              if (bad_n[c] == TO) begin
                ph[c] = P_PULSE; left[c] = PULSE;
                if (rtc[c] < 255) rtc[c]++;
              end
            end
          end
          P_UP: if (!good) start_hunt(c);
          P_PULSE: begin
            left[c]--;
            if (left[c] == 0) begin ph[c] = P_RXW; seen[c] = 0; end
          end
          P_RXW: begin
            if (seen[c] && rxd2) start_hunt(c);
            else if (!rxd2) seen[c] = 1;
          end
          default: ph[c] = P_IDLE;
        endcase
      end
    end
    m_rxdp = any_p;
    m_uca  = 1;
    run = txd2 ? ((run < 1000) ? run + 1 : run) : 0;
    m_txrst = (run < RST_SYNC_N);
    rx_prev = rxd2;
    txd2 = txd1; txd1 = gt_reset_tx_done;
    rxd2 = rxd1; rxd1 = gt_reset_rx_done;
    lk2 = lk1; lk1 = rx_block_lock;
    br2 = br1; br1 = rx_high_ber;
    ticks++;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge gt_txusrclk or posedge gt_tx_reset);
      if (gt_tx_reset) model_reset();
      else model_step();
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    logic [8*CH-1:0] exp_rc;
    forever begin
      @(negedge gt_txusrclk);
      if (chk_en) begin
        for (int c = 0; c < CH; c++) exp_rc[8*c +: 8] = 8'(rtc[c]);
        check("m_userclk", 64'(userclk_tx_active), 64'(m_uca));
        check("m_tx_rst", 64'(tx_rst), 64'(m_txrst));
        check("m_link_up", 64'(link_up), 64'(m_link));
        check("m_rxdp", 64'(rx_datapath_reset), 64'(m_rxdp));
        check("m_retrain_count", 64'(retrain_count), 64'(exp_rc));
        check("m_status_led", 64'(status_led), 64'(m_led));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge gt_txusrclk);
  endtask

  task automatic wait_rxdp(input logic v, input int lim, input string nm);
    int n;
    n = 0;
    while (rx_datapath_reset !== v && n < lim) begin
      tick(1);
      n++;
    end
    check(nm, 64'(rx_datapath_reset), 64'(v));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_userclk"}, 64'(userclk_tx_active), 64'd0);
    check({tag, "_tx_rst"}, 64'(tx_rst), 64'd1);
    check({tag, "_link_up"}, 64'(link_up), 64'd0);
    check({tag, "_rxdp"}, 64'(rx_datapath_reset), 64'd0);
    check({tag, "_retrain_count"}, 64'(retrain_count), 64'd0);
    check({tag, "_status_led"}, 64'(status_led), 64'd0);
  endtask

  initial begin
    int ups, highs;
    gt_reset_tx_done = 0; gt_reset_rx_done = 0; rx_block_lock = '0; rx_high_ber = '0;
    tick(3);
    check_reset_outputs("rst");
    chk_en = 1;

    // Release; tx_done at cycle 0.
    gt_tx_reset = 0; gt_reset_tx_done = 1;
    tick(1);
    check("uca_cycle1", 64'(userclk_tx_active), 64'd1);
    check("txrst_cycle1", 64'(tx_rst), 64'd1);
    tick(4);
    check("txrst_cycle5", 64'(tx_rst), 64'd1);
    tick(1);
    check("txrst_cycle6", 64'(tx_rst), 64'd0);

    // Both channels reach S_WAIT_LOCK after edge 9; lock[0] raised then.
    gt_reset_rx_done = 1;
    tick(3);
    rx_block_lock[0] = 1'b1;
    tick(11);
    check("link0_edge20", 64'(link_up[0]), 64'd0);
    tick(1);
    check("link0_edge21", 64'(link_up[0]), 64'd1);
    check("led0_up", 64'(status_led[0]), 64'd1);

    // Channel 1 times out at edge 41; pulse seen on edges 42..45.
    tick(20);
    check("rxdp_edge41", 64'(rx_datapath_reset), 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("rxdp_pulse", 64'(rx_datapath_reset), 64'd1);
    end
    tick(1);
    check("rxdp_edge46", 64'(rx_datapath_reset), 64'd0);
    check("rtc_ch1_one", 64'(retrain_count), 64'h0100);

    // RX reset cycle sends both channels back to hunting together.
    rx_block_lock = '0;
    gt_reset_rx_done = 0; tick(4); gt_reset_rx_done = 1; tick(3);
    rx_block_lock = 2'b11;
    ups = 0;
    for (int i = 1; i <= 19; i++) begin
      if (i == 8) rx_block_lock[0] = 1'b0;
      if (i == 9) rx_block_lock[0] = 1'b1;
      tick(1);
      ups += int'(link_up[0]);
    end
    check("glitch_no_up", 64'(ups), 64'd0);
    tick(1);
    check("up_after_glitch", 64'(link_up[0]), 64'd1);

    // High BER drops the link.
    tick(2);
    rx_high_ber[0] = 1'b1;
    tick(2);
    check("ber_link_still_up", 64'(link_up[0]), 64'd1);
    tick(2);
    check("ber_link_down", 64'(link_up[0]), 64'd0);
    rx_high_ber[0] = 1'b0;
    tick(20);

    // Simultaneous timeouts merge into one pulse.
    rx_block_lock = '0;
    gt_reset_rx_done = 0; tick(4); gt_reset_rx_done = 1; tick(3);
    highs = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      highs += int'(rx_datapath_reset);
    end
    check("merged_pulse_width", 64'(highs), 64'd4);
    check("rtc_both", 64'(retrain_count), 64'h0201);

    // Saturation.
    for (int k = 0; k < 300; k++) begin
      gt_reset_rx_done = 0; tick(4); gt_reset_rx_done = 1;
      wait_rxdp(1'b1, 60, "sat_rise");
      wait_rxdp(1'b0, 10, "sat_fall");
    end
    check("rtc_saturated", 64'(retrain_count), 64'hFFFF);

    // Async reset mid-pulse.
    gt_reset_rx_done = 0; tick(4); gt_reset_rx_done = 1;
    wait_rxdp(1'b1, 60, "f_rise");
    tick(2);
    #3 gt_tx_reset = 1'b1;
    #1 check_reset_outputs("async");
    tick(3);
    gt_tx_reset = 1'b0;
    tick(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
